// File: rtl/sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } sweep_state_t;

    localparam int ORDER_BIN  = 0;
    localparam int ORDER_GRAY = 1;

    function automatic logic [7:0] bin2gray(input logic [7:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sweep_seq_gen.sv
// Vector sequencer: walks the index through every input vector, holding each for HOLD cycles.
module sweep_seq_gen
    import sweep_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int HOLD  = 50,
    parameter int ORDER = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            run,
    output logic [N_IN-1:0] stim,
    output logic            sample,
    output logic            last
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [HW-1:0] HOLD_END = HW'(HOLD - 1);

    logic [N_IN-1:0] index;
    logic [N_IN-1:0] index_next;
    logic [HW-1:0]   hold_cnt;

    function automatic logic [N_IN-1:0] map_order(input logic [N_IN-1:0] idx);
        if (ORDER == ORDER_GRAY) begin
            return N_IN'(bin2gray(8'(idx)));
        end
        return idx;
    endfunction

    assign index_next = index + N_IN'(1);
    assign sample     = run && (hold_cnt == HOLD_END);
    assign last       = (index == LAST_IDX);

    // The last vector stays on stim after its sample so the index never wraps back to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index    <= '0;
            hold_cnt <= '0;
            stim     <= '0;
        end else if (load) begin
            index    <= '0;
            hold_cnt <= '0;
            stim     <= map_order('0);
        end else if (run) begin
            if (hold_cnt == HOLD_END) begin
                hold_cnt <= '0;
                if (!last) begin
                    index <= index_next;
                    stim  <= map_order(index_next);
                end
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table checker: drives every input vector into a combinational DUT
// and compares the sampled output against a golden table latched at start.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int HOLD  = 50,
    parameter int ORDER = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(2**N_IN)-1:0]   golden,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        stim,
    output logic                   stim_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_fail,
    output logic                   fail_seen
);

    sweep_state_t         state;
    logic [(2**N_IN)-1:0] golden_q;
    logic                 load;
    logic                 run;
    logic                 sample;
    logic                 last;
    logic                 mismatch;

    assign load     = (state == IDLE) && start;
    assign run      = (state == DRIVE);
    assign mismatch = (dut_out != golden_q[stim]);

    sweep_seq_gen #(
        .N_IN  (N_IN),
        .HOLD  (HOLD),
        .ORDER (ORDER)
    ) u_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .run    (run),
        .stim   (stim),
        .sample (sample),
        .last   (last)
    );

    // pass is resolved on entry to DONE so the final sample is already included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            golden_q   <= '0;
            stim_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= DRIVE;
                        golden_q   <= golden;
                        stim_valid <= 1'b1;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        if (mismatch) begin
                            err_count <= err_count + (N_IN+1)'(1);
                            if (!fail_seen) begin
                                first_fail <= stim;
                                fail_seen  <= 1'b1;
                            end
                        end
                        if (last) begin
                            state      <= DONE;
                            stim_valid <= 1'b0;
                            done       <= 1'b1;
                            pass       <= !mismatch && (err_count == '0);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, self-checking stimulus engine for the gate-level boolean function blocks. On `start` it enumerates every input vector of an N-input combinational DUT and holds each vector for a programmable number of cycles. It samples the DUT output at the end of each hold and compares it against a golden truth table, accumulating an error count and the first failing vector. It sits beside the DUT in a synthesizable test harness and replaces the hand-written per-function `initial` stimulus lists.

## Interface
- `N_IN`, 4: DUT input count, legal range 1..8.
- `HOLD`, 50: cycles each vector is held, minimum 2.
- `ORDER`, 0: enumeration order. 0 = binary count, 1 = reflected Gray code.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  run request, sampled only in IDLE.
- `golden`  in  2^N_IN  expected output. Bit v is the expected output for stimulus value v.
- `dut_out`  in  1  DUT output under test.
- `stim`  out  N_IN  vector driven to DUT inputs. MSB is the first function input (A).
- `stim_valid`  out  1  high while `stim` carries a test vector.
- `busy`  out  1  high from the cycle after `start` accept through the DONE cycle.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  high when the last completed run had zero mismatches.
- `err_count`  out  N_IN+1  mismatch count of the last/current run.
- `first_fail`  out  N_IN  stimulus value of the first mismatch.
- `fail_seen`  out  1  at least one mismatch in the current/last run.

## Operation
- The FSM has three states: IDLE, DRIVE and DONE.
- **IDLE to DRIVE.** Transition occurs on `start`=1.
  - `golden` is latched into an internal register; later changes are ignored until the next run.
  - Index, hold counter, `err_count`, `fail_seen`, `first_fail` and `pass` all clear.
- **DRIVE.**
  - `stim` = seq(index), where seq is identity for ORDER=0 and idx^(idx>>1) for ORDER=1.
  - `stim_valid`=1 throughout.
  - The hold counter counts 0..HOLD-1.
  - On hold count HOLD-1, `dut_out` is compared with `golden_q[stim]`. On mismatch:
    - `err_count` increments.
    - If `fail_seen` was 0, `first_fail` takes the current `stim` and `fail_seen` goes to 1.
  - On hold count HOLD-1, the index advances and the hold counter returns to 0.
- **DRIVE to DONE.** Transition occurs on the sample cycle of index 2^N_IN-1. Index wrap is not allowed to re-enter vector 0.
- **DONE.**
  - `done`=1, `busy`=1, `stim_valid`=0.
  - `pass` is set to (`err_count`==0), including the final sample.
  - The next state is IDLE unconditionally.
- `start` in DRIVE or DONE is ignored and not queued.
- Results (`pass`, `err_count`, `first_fail`, `fail_seen`) hold in IDLE until the next accepted `start`.
- `err_count` width N_IN+1 covers the maximum of 2^N_IN mismatches; no saturation logic is needed.
- `stim` holds its last vector in DONE and IDLE. DUT consumers qualify it with `stim_valid`.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces:
  - state IDLE;
  - `stim`=0, `stim_valid`=0, `busy`=0, `done`=0;
  - `pass`=0, `err_count`=0, `first_fail`=0, `fail_seen`=0.
- Reset mid-run aborts immediately. No `done` pulse is produced and results are cleared.
- With `start` high in cycle 0:
  - cycles 1 .. 2^N_IN·HOLD are DRIVE;
  - vector k occupies cycles k·HOLD+1 .. (k+1)·HOLD;
  - `done` is high in cycle 2^N_IN·HOLD+1;
  - IDLE resumes at cycle 2^N_IN·HOLD+2, where a new `start` is accepted.
- `dut_out` is sampled HOLD-1 cycles after the vector change. The DUT combinational path must settle within that window.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `sweep_pkg` holds:
  - the state enum `sweep_state_t` (IDLE, DRIVE, DONE);
  - localparams `ORDER_BIN`=0 and `ORDER_GRAY`=1;
  - function `bin2gray`.
- Sub-module `sweep_seq_gen` contains the index counter, hold counter, last-vector detect and the ORDER mapping to `stim`. The top level keeps the FSM, golden latch and checker.

## Test plan
- **Correct DUT, binary order.** N_IN=2, HOLD=4, ORDER=0, `golden`=4'b1100 (F1 = A|AB = A), correct DUT. `stim` runs 0,1,2,3, each held 4 cycles. `done` at cycle 17, `pass`=1, `err_count`=0, `fail_seen`=0.
- **Faulty DUT.** Same configuration, DUT stuck at 0. `err_count`=2, `first_fail`=2, `fail_seen`=1, `pass`=0.
- **Gray order.** N_IN=3, HOLD=2, ORDER=1. `stim` sequence is 0,1,3,2,6,7,5,4, with exactly one bit change per step. `done` at cycle 17.
- **Start during run.** `start` pulsed during DRIVE and during DONE is ignored, with a single `done`. `start` at IDLE re-entry (cycle 18) launches a fresh run with results cleared.
- **Golden change mid-run.** `golden` changed during DRIVE does not affect results. `pass` reflects the value latched at start.
- **Reset mid-run.** `rst_n` low at cycle 7: next cycle all outputs are 0, with no `done` pulse. A subsequent `start` runs normally to completion.
